// File: rtl/cdb_arbiter_pkg.sv
// Shared backend types for the common data bus.
//   ROB_IDX / PRF_IDX : ROB and physical register index widths
//   CDB_WIDTH         : number of CDB broadcast slots
//   cdb_pkt_t         : one writeback result as broadcast on the CDB
package cdb_arbiter_pkg;

    localparam int ROB_IDX   = 6;
    localparam int PRF_IDX   = 7;
    localparam int CDB_WIDTH = 2;

    typedef struct packed {
        logic [ROB_IDX-1:0] rob_id;
        logic [PRF_IDX-1:0] rd_phy;
        logic [4:0]         rd_arch;
        logic [31:0]        rd_value;
    } cdb_pkt_t;

endpackage

// File: rtl/cdb_arbiter_rr_select.sv
// Combinational round-robin pick of up to NUM_CDB requesters.
// Scans from rr_ptr_i upward with wrap-around and takes the first NUM_CDB
// valid requesters; the j-th one found is routed to slot j.
//   req_valid_i  : requester valid vector
//   rr_ptr_i     : highest-priority requester index
//   grant_o      : one bit per granted requester
//   slot_valid_o : slot k has a winner
//   slot_idx_o   : requester index feeding slot k
//   any_grant_o  : at least one grant
//   last_idx_o   : index of the last grant in scan order
module cdb_arbiter_rr_select
    import cdb_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int NUM_CDB = CDB_WIDTH,
    parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0]              req_valid_i,
    input  logic [PTR_W-1:0]                rr_ptr_i,
    output logic [NUM_REQ-1:0]              grant_o,
    output logic [NUM_CDB-1:0]              slot_valid_o,
    output logic [NUM_CDB-1:0][PTR_W-1:0]   slot_idx_o,
    output logic                            any_grant_o,
    output logic [PTR_W-1:0]                last_idx_o
);

    logic [PTR_W:0]   idx_wide;
    logic [PTR_W-1:0] idx;
    int               cnt;

    always_comb begin
        grant_o      = '0;
        slot_valid_o = '0;
        slot_idx_o   = '0;
        any_grant_o  = 1'b0;
        last_idx_o   = '0;
        idx_wide     = '0;
        idx          = '0;
        cnt          = 0;
        for (int off = 0; off < NUM_REQ; off++) begin
            // Explicit wrap so a non-power-of-two NUM_REQ still scans correctly.
            idx_wide = {1'b0, rr_ptr_i} + (PTR_W+1)'(off);
            if (idx_wide >= (PTR_W+1)'(NUM_REQ)) begin
                idx_wide = idx_wide - (PTR_W+1)'(NUM_REQ);
            end
            idx = idx_wide[PTR_W-1:0];
            if (req_valid_i[idx] && (cnt < NUM_CDB)) begin
                grant_o[idx] = 1'b1;
                for (int k = 0; k < NUM_CDB; k++) begin
                    if (k == cnt) begin
                        slot_valid_o[k] = 1'b1;
                        slot_idx_o[k]   = idx;
                    end
                end
                any_grant_o = 1'b1;
                last_idx_o  = idx;
                cnt         = cnt + 1;
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB arbiter: grants up to NUM_CDB writeback requesters per cycle in
// round-robin order and registers the winners onto the CDB slots.
//   clk_i, rst_i     : clock, asynchronous active-high reset
//   backend_flush_i  : kills this cycle's grants and clears the bus
//   req_valid_i      : requester holds a completed result
//   req_ready_o      : requester granted this cycle (combinational)
//   req_data_i       : requester payloads
//   cdb_valid_o      : slot broadcasts this cycle
//   cdb_data_o       : slot payloads
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int NUM_CDB = CDB_WIDTH
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        backend_flush_i,
    input  logic     [NUM_REQ-1:0]      req_valid_i,
    output logic     [NUM_REQ-1:0]      req_ready_o,
    input  cdb_pkt_t [NUM_REQ-1:0]      req_data_i,
    output logic     [NUM_CDB-1:0]      cdb_valid_o,
    output cdb_pkt_t [NUM_CDB-1:0]      cdb_data_o
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0]               rr_ptr_q, rr_ptr_d;
    logic [NUM_CDB-1:0]             cdb_valid_q, cdb_valid_d;
    cdb_pkt_t [NUM_CDB-1:0]         cdb_data_q, cdb_data_d;

    logic [NUM_REQ-1:0]             grant;
    logic [NUM_CDB-1:0]             slot_valid;
    logic [NUM_CDB-1:0][PTR_W-1:0]  slot_idx;
    logic                           any_grant;
    logic [PTR_W-1:0]               last_idx;
    logic [PTR_W:0]                 ptr_next;

    cdb_arbiter_rr_select #(
        .NUM_REQ (NUM_REQ),
        .NUM_CDB (NUM_CDB),
        .PTR_W   (PTR_W)
    ) u_rr_select (
        .req_valid_i  (req_valid_i),
        .rr_ptr_i     (rr_ptr_q),
        .grant_o      (grant),
        .slot_valid_o (slot_valid),
        .slot_idx_o   (slot_idx),
        .any_grant_o  (any_grant),
        .last_idx_o   (last_idx)
    );

    // Reset forces ready low as well, so no requester retires a result
    // into a bus that is being cleared.
    assign req_ready_o = (backend_flush_i || rst_i) ? '0 : grant;

    always_comb begin
        ptr_next = {1'b0, last_idx} + (PTR_W+1)'(1);
        if (ptr_next >= (PTR_W+1)'(NUM_REQ)) begin
            ptr_next = '0;
        end
        rr_ptr_d = rr_ptr_q;
        if (backend_flush_i) begin
            rr_ptr_d = '0;
        end else if (any_grant) begin
            rr_ptr_d = ptr_next[PTR_W-1:0];
        end
    end

    // Unused slots drop valid but keep stale data to avoid needless toggling.
    always_comb begin
        cdb_valid_d = '0;
        cdb_data_d  = cdb_data_q;
        for (int k = 0; k < NUM_CDB; k++) begin
            if (slot_valid[k] && !backend_flush_i) begin
                cdb_valid_d[k] = 1'b1;
                cdb_data_d[k]  = req_data_i[slot_idx[k]];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_ptr_q    <= '0;
            cdb_valid_q <= '0;
            cdb_data_q  <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            cdb_valid_q <= cdb_valid_d;
            cdb_data_q  <= cdb_data_d;
        end
    end

    assign cdb_valid_o = cdb_valid_q;
    assign cdb_data_o  = cdb_data_q;

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Shares the NUM_CDB common-data-bus broadcast slots among NUM_REQ functional-unit writeback requesters in the backend: int, int-mul/div, branch and load/store. Each cycle it grants up to NUM_CDB requesters in round-robin order and registers the winners' results onto the CDB slots one cycle later. The CDB feeds the ROB, RAT, PRF and all reservation stations. It also squashes in-flight broadcasts on backend_flush.

## Interface
Parameters:
- NUM_REQ, 4, number of writeback requesters (int, intm, br, mem).
- NUM_CDB, 2, number of CDB broadcast slots; 1 ≤ NUM_CDB ≤ NUM_REQ.
- ROB_IDX, cpu_params value, ROB index width.
- PRF_IDX, cpu_params value, physical register index width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- backend_flush  in  1  pipeline flush from the ROB.
- req_valid  in  NUM_REQ  requester i holds a completed result.
- req_ready  out  NUM_REQ  requester i is granted this cycle; the handshake fires on valid&ready.
- req_data  in  NUM_REQ × cdb_pkt_t  payload: rob_id, rd_phy, rd_arch[4:0], rd_value[31:0].
- cdb_valid  out  NUM_CDB  slot k broadcasts this cycle.
- cdb_data  out  NUM_CDB × cdb_pkt_t  slot k payload.

## Operation
- Round-robin pointer rr_ptr (log2 NUM_REQ bits) names the highest-priority requester.
- Scan order: rr_ptr, rr_ptr+1, …, wrapping mod NUM_REQ.
- The first NUM_CDB valid requesters in scan order are granted.
- The j-th grant in scan order (j = 0..NUM_CDB-1) is routed to slot j.
- req_ready[i] is combinational: 1 iff i is granted and backend_flush = 0.
  - It depends on req_valid and rr_ptr only, never on req_ready.
- At most one grant per requester per cycle.
- Pointer update on any grant: rr_ptr ← (index of last granted requester + 1) mod NUM_REQ.
  - No grant: rr_ptr holds.
  - Pointer arithmetic wraps explicitly, so NUM_REQ may be a non-power-of-two.
- Output register: cdb_valid[k]/cdb_data[k] load from slot k's winner at the next clk edge.
  - An unused slot loads cdb_valid = 0; cdb_data holds its old value.
- Flush:
  - backend_flush = 1 forces all req_ready = 0 that cycle.
  - At the edge, all cdb_valid clear to 0 and rr_ptr resets to 0.
  - Broadcasts already on the bus in the flush cycle remain visible that cycle; consumers ignore them under flush.
- Fairness: any continuously valid requester is granted within ceil(NUM_REQ/NUM_CDB) cycles.
- Requesters must hold req_valid and req_data stable until granted. Dropping valid before grant is legal (the FU was flushed).

## Timing
- Reset values (asynchronous): cdb_valid = 0, cdb_data = 0, rr_ptr = 0. req_ready is combinational, so it is 0 whenever rst = 1.
- Latency: grant in cycle N gives a broadcast in cycle N+1. Throughput is NUM_CDB results per cycle, sustained.
- All valid (4 requesters, 2 slots, rr_ptr = 0): grants {0,1}, then {2,3}, then {0,1}, …
- Only one valid requester: granted every cycle into slot 0.
- No valid requester: all cdb_valid go 0 next cycle; rr_ptr holds.
- Flush and valid requests in the same cycle: no grants, cdb_valid = 0 next cycle.
- Reset deasserting mid-stream: first grants use rr_ptr = 0.

## Structure
- cdb_pkt_t and CDB_WIDTH (= NUM_CDB) belong in uop_types/cpu_params, shared with ROB, RAT, PRF and the reservation stations.
- One sub-module, rr_select: combinational rotate, priority-pick-N and un-rotate. It returns a grant vector plus per-slot requester indices.
- Top level holds rr_ptr, the output registers and the flush logic.

## Test plan
- Reset: assert rst mid-cycle, with all req_valid = 1 → cdb_valid = 0 immediately and req_ready = 0 while rst = 1. After release, first grants are {0,1}.
- Saturation: req_valid = 4'b1111 for 6 cycles, rd_value = 0x100 + i → slots broadcast requester pairs (0,1), (2,3), (0,1), … one cycle after grant. No result is lost or duplicated.
- Wrap: rr_ptr = 3 and req_valid = 4'b1001 → grants 3→slot 0, 0→slot 1; rr_ptr becomes 1.
- Sparse: only requester 2 valid for 3 cycles → req_ready = 4'b0100 each cycle. cdb_valid = 2'b01 with slot 0 rob_id matching, latency 1.
- Flush: backend_flush = 1 with req_valid = 4'b1111 → req_ready = 0. Next cycle cdb_valid = 0 and rr_ptr = 0.
- Fairness: random req_valid for 10k cycles → every held request is granted within 2 cycles; scoreboard matches broadcast payloads against handshakes.
